// File: rtl/can_mac_tx_framer.sv
// CAN MAC transmit framer: latches a standard-frame descriptor, appends CRC-15
// and streams the unstuffed frame MSB-first to the bit stuffer.
module can_mac_tx_framer (
  input  logic        clk,
  input  logic        reset,
  input  logic        frame_valid,
  output logic        frame_ready,
  input  logic [10:0] id,
  input  logic        rtr,
  input  logic [3:0]  dlc,
  input  logic [63:0] data,
  output logic        bit_out,
  output logic        bit_valid,
  input  logic        bit_ready,
  output logic        stuffing_enable,
  output logic        busy,
  output logic        done
);

  typedef enum logic [2:0] {IDLE, HDR, DATA, CRC, TAIL} state_t;

  state_t      state_q, state_d;
  logic [18:0] hdr_q, hdr_d;
  logic [63:0] data_q, data_d;
  logic [14:0] crc_q, crc_d, crc_step;
  logic [6:0]  cnt_q, cnt_d;
  logic [6:0]  nbits_q, nbits_d;
  logic        done_q, done_d;
  logic [3:0]  nbytes;
  logic        xfer;

  assign nbytes          = rtr ? 4'd0 : (dlc[3] ? 4'd8 : dlc);
  assign bit_valid       = (state_q != IDLE);
  assign busy            = (state_q != IDLE);
  assign frame_ready     = (state_q == IDLE) && reset;
  assign stuffing_enable = (state_q == HDR) || (state_q == DATA) || (state_q == CRC);
  assign done            = done_q;
  assign xfer            = bit_valid && bit_ready;

  // Each field is held in a register whose MSB is the bit on the wire.
  always_comb begin
    bit_out = 1'b1;
    case (state_q)
      HDR:     bit_out = hdr_q[18];
      DATA:    bit_out = data_q[63];
      CRC:     bit_out = crc_q[14];
      default: bit_out = 1'b1;
    endcase
  end

  assign crc_step = {crc_q[13:0], 1'b0} ^ ((bit_out ^ crc_q[14]) ? 15'h4599 : 15'h0000);

  always_comb begin
    state_d = state_q;
    hdr_d   = hdr_q;
    data_d  = data_q;
    crc_d   = crc_q;
    cnt_d   = cnt_q;
    nbits_d = nbits_q;
    done_d  = 1'b0;
    case (state_q)
      IDLE: begin
        if (frame_valid && frame_ready) begin
          hdr_d   = {1'b0, id, rtr, 1'b0, 1'b0, dlc};
          data_d  = data;
          nbits_d = {nbytes, 3'b000};
          crc_d   = 15'h0000;
          cnt_d   = 7'd0;
          state_d = HDR;
        end
      end
      HDR: begin
        if (xfer) begin
          hdr_d = {hdr_q[17:0], 1'b0};
          crc_d = crc_step;
          if (cnt_q == 7'd18) begin
            cnt_d   = 7'd0;
            state_d = (nbits_q != 7'd0) ? DATA : CRC;
          end else begin
            cnt_d = cnt_q + 7'd1;
          end
        end
      end
      DATA: begin
        if (xfer) begin
          data_d = {data_q[62:0], 1'b0};
          crc_d  = crc_step;
          if (cnt_q == nbits_q - 7'd1) begin
            cnt_d   = 7'd0;
            state_d = CRC;
          end else begin
            cnt_d = cnt_q + 7'd1;
          end
        end
      end
      CRC: begin
        // The CRC register is final here, so it doubles as the output shifter.
        if (xfer) begin
          crc_d = {crc_q[13:0], 1'b0};
          if (cnt_q == 7'd14) begin
            cnt_d   = 7'd0;
            state_d = TAIL;
          end else begin
            cnt_d = cnt_q + 7'd1;
          end
        end
      end
      TAIL: begin
        if (xfer) begin
          if (cnt_q == 7'd9) begin
            cnt_d   = 7'd0;
            done_d  = 1'b1;
            state_d = IDLE;
          end else begin
            cnt_d = cnt_q + 7'd1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= IDLE;
      hdr_q   <= '0;
      data_q  <= '0;
      crc_q   <= '0;
      cnt_q   <= '0;
      nbits_q <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      hdr_q   <= hdr_d;
      data_q  <= data_d;
      crc_q   <= crc_d;
      cnt_q   <= cnt_d;
      nbits_q <= nbits_d;
      done_q  <= done_d;
    end
  end

endmodule
